// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MIPS multiply/divide unit with start/busy/done handshake
// Shift-add multiply (MUL_BITS per step) and restoring divide on magnitudes, sign fix-up in FIX.
module mdu_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int MUL_STEPS = WIDTH / MUL_BITS;
    localparam int CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STEPS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q;
    logic                 div_q;
    logic                 neg_q;
    logic                 rneg_q;
    logic                 dbz_pend_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 dbz_q;

    logic                 accept;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [MUL_BITS-1:0]  digit;
    logic [WIDTH+MUL_BITS-1:0] pp;
    logic [WIDTH+MUL_BITS-1:0] msum;
    logic [WIDTH:0]       sh;
    logic                 ge;
    logic [WIDTH-1:0]     rem_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic                 last_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;

    assign accept = start & ~cancel & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign a_neg  = ~op[0] & a[WIDTH-1];
    assign b_neg  = ~op[0] & b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    // Multiply: low half of acc holds the unconsumed multiplier bits, product shifts in from the top.
    always_comb begin
        digit = acc_q[MUL_BITS-1:0];
        pp    = {{MUL_BITS{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, digit};
        msum  = {{MUL_BITS{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + pp;
    end

    // Divide: acc = {remainder, dividend/quotient}; a true remainder always fits WIDTH bits.
    always_comb begin
        sh    = acc_q[2*WIDTH-1:WIDTH-1];
        ge    = sh >= {1'b0, mcand_q};
        rem_d = ge ? (sh[WIDTH-1:0] - mcand_q) : sh[WIDTH-1:0];
    end

    always_comb begin
        acc_d     = acc_q;
        last_step = 1'b0;
        if (div_q) begin
            acc_d     = {rem_d, acc_q[WIDTH-2:0], ge};
            last_step = (cnt_q == DIV_LAST);
        end else begin
            acc_d     = {msum, acc_q[WIDTH-1:MUL_BITS]};
            last_step = (cnt_q == MUL_LAST);
        end
    end

    // Divide-by-zero leaves |a| as remainder, so the remainder sign fix restores the original a.
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        hi_d     = prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = prod_fix[WIDTH-1:0];
        if (div_q) begin
            hi_d = rneg_q ? -rem : rem;
            lo_d = dbz_pend_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= 1'b0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            cnt_q      <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dbz_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        div_q      <= op[1];
                        neg_q      <= a_neg ^ b_neg;
                        rneg_q     <= op[1] & a_neg;
                        dbz_pend_q <= op[1] & (b == '0);
                        mcand_q    <= op[1] ? b_mag : a_mag;
                        acc_q      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= op[1] ? S_DIV : S_MUL;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL, S_DIV: begin
                    if (cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_step) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        dbz_q   <= dbz_pend_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dbz  = dbz_q;

endmodule
